// File: rtl/quat_stream_rx.sv
// Serial-to-parallel quaternion receiver: collects q0..q3 beats into a registered output.
// Optional macro QUAT_RX_CONJ_EN adds s_conj, which sign-flips t1..t3 when set on the q3 beat.
module quat_stream_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_first,
`ifdef QUAT_RX_CONJ_EN
  input  logic        s_conj,
`endif
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] t0,
  output logic [31:0] t1,
  output logic [31:0] t2,
  output logic [31:0] t3,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {WAIT_Q0, WAIT_Q1, WAIT_Q2, WAIT_Q3} state_e;

  state_e      state_q, state_d;
  logic [31:0] stg0_q, stg0_d, stg1_q, stg1_d, stg2_q, stg2_d;
  logic [31:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic        m_valid_q, m_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        accept;
  logic        bad;
  logic [31:0] flip;

  // Only the q3 beat can stall, and only behind an undrained quaternion.
  assign s_ready = (state_q != WAIT_Q3) || !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

`ifdef QUAT_RX_CONJ_EN
  assign flip = {s_conj, 31'b0};
`else
  assign flip = 32'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_Q0;
      stg0_q      <= '0;
      stg1_q      <= '0;
      stg2_q      <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      t3_q        <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stg0_q      <= stg0_d;
      stg1_q      <= stg1_d;
      stg2_q      <= stg2_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      t3_q        <= t3_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stg0_d      = stg0_q;
    stg1_d      = stg1_q;
    stg2_d      = stg2_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    t3_d        = t3_q;
    m_valid_d   = m_valid_q && !m_ready;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bad         = 1'b0;

    if (accept) begin
      // A leading beat always restarts the frame, even if one was in progress.
      if (s_first) begin
        bad     = (state_q != WAIT_Q0);
        stg0_d  = s_data;
        state_d = WAIT_Q1;
      end else begin
        case (state_q)
          WAIT_Q0: bad = 1'b1;
          WAIT_Q1: begin
            stg1_d  = s_data;
            state_d = WAIT_Q2;
          end
          WAIT_Q2: begin
            stg2_d  = s_data;
            state_d = WAIT_Q3;
          end
          WAIT_Q3: begin
            t0_d      = stg0_q;
            t1_d      = stg1_q ^ flip;
            t2_d      = stg2_q ^ flip;
            t3_d      = s_data ^ flip;
            m_valid_d = 1'b1;
            state_d   = WAIT_Q0;
          end
        endcase
      end
    end

    if (bad) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign m_valid   = m_valid_q;
  assign t0        = t0_q;
  assign t1        = t1_q;
  assign t2        = t2_q;
  assign t3        = t3_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_quat_stream_rx.sv
// Self-checking bench for quat_stream_rx: directed test-plan steps followed by random traffic,
// compared every cycle against a queue-based frame model. Honours QUAT_RX_CONJ_EN.
module tb_quat_stream_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_first;
  logic        s_conj;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] t0, t1, t2, t3;
  logic        frame_err;
  logic [7:0]  err_cnt;

`ifdef QUAT_RX_CONJ_EN
  localparam bit ConjEn = 1'b1;
`else
  localparam bit ConjEn = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model: the words of the frame in progress, plus the expected output register.
  logic [31:0] partial[$];
  logic [31:0] expT[4];
  logic        expValid;
  logic        expErr;
  int          expCnt;

  always #5 clk = ~clk;

  quat_stream_rx dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_first   (s_first),
`ifdef QUAT_RX_CONJ_EN
    .s_conj    (s_conj),
`endif
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .t0        (t0),
    .t1        (t1),
    .t2        (t2),
    .t3        (t3),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllOutputs();
    checkOutput("m_valid", {31'b0, m_valid}, {31'b0, expValid});
    checkOutput("t0", t0, expT[0]);
    checkOutput("t1", t1, expT[1]);
    checkOutput("t2", t2, expT[2]);
    checkOutput("t3", t3, expT[3]);
    checkOutput("frame_err", {31'b0, frame_err}, {31'b0, expErr});
    checkOutput("err_cnt", {24'b0, err_cnt}, expCnt[31:0]);
  endtask

  task automatic applyReset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = '0;
    s_conj  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    partial.delete();
    for (int i = 0; i < 4; i++) expT[i] = '0;
    expValid = 1'b0;
    expErr   = 1'b0;
    expCnt   = 0;
    checkAllOutputs();
    #1;
    checkOutput("s_ready_after_reset", {31'b0, s_ready}, 32'd1);
  endtask

  // One clock cycle: drive inputs, check s_ready, advance the model and the DUT, check outputs.
  task automatic applyStimulus(input logic v, input logic first, input logic [31:0] data,
                               input logic conj, input logic mready);
    logic expReady;
    logic acc;
    logic nextValid;
    logic [31:0] mask;
    s_valid = v;
    s_first = first;
    s_data  = data;
    s_conj  = conj;
    m_ready = mready;
    #1;
    expReady = !(partial.size() == 3 && expValid && !mready);
    checkOutput("s_ready", {31'b0, s_ready}, {31'b0, expReady});

    acc       = v && expReady;
    nextValid = expValid && !mready;
    expErr    = 1'b0;
    if (acc) begin
      if (first) begin
        if (partial.size() != 0) expErr = 1'b1;
        partial.delete();
        partial.push_back(data);
      end else if (partial.size() == 0) begin
        expErr = 1'b1;
      end else begin
        partial.push_back(data);
      end
      if (partial.size() == 4) begin
        mask = (ConjEn && conj) ? 32'h8000_0000 : 32'h0;
        expT[0]   = partial[0];
        expT[1]   = partial[1] ^ mask;
        expT[2]   = partial[2] ^ mask;
        expT[3]   = partial[3] ^ mask;
        nextValid = 1'b1;
        partial.delete();
      end
    end
    expValid = nextValid;
    if (expErr && expCnt < 255) expCnt++;

    @(posedge clk);
    #1;
    checkAllOutputs();
  endtask

  task automatic sendFrame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] d, input logic conj, input logic mready);
    applyStimulus(1'b1, 1'b1, a, 1'b0, mready);
    applyStimulus(1'b1, 1'b0, b, 1'b0, mready);
    applyStimulus(1'b1, 1'b0, c, 1'b0, mready);
    applyStimulus(1'b1, 1'b0, d, conj, mready);
  endtask

  initial begin
    m_ready = 1'b1;
    applyReset();

    // Basic frame
    sendFrame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b0, 1'b1);
    checkOutput("basic_t0", t0, 32'h3F800000);
    checkOutput("basic_t3", t3, 32'h40800000);
    checkOutput("basic_valid", {31'b0, m_valid}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("basic_valid_drop", {31'b0, m_valid}, 32'd0);

    // Backpressure: two frames with m_ready low, second q3 stalls
    sendFrame(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h66666666, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h77777777, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h88888888, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h88888888, 1'b0, 1'b0);
    checkOutput("bp_hold_t0", t0, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 32'h88888888, 1'b0, 1'b1);
    checkOutput("bp_frame2_t3", t3, 32'h88888888);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Framing error with resync on an early s_first
    applyStimulus(1'b1, 1'b1, 32'hAAAA0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b1);
    checkOutput("resync_err", {31'b0, frame_err}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h40000000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h40400000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h40800000, 1'b0, 1'b1);
    checkOutput("resync_t0", t0, 32'h3F800000);
    checkOutput("resync_cnt", {24'b0, err_cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Stray beats saturate the error counter
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b1);
    checkOutput("stray_sat", {24'b0, err_cnt}, 32'hFF);
    sendFrame(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 1'b0, 1'b1);
    checkOutput("stray_recover_t2", t2, 32'h090A0B0C);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Conjugate request (only flips signs when the feature is built in)
    sendFrame(32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000, 1'b1, 1'b1);
    checkOutput("conj_t0", t0, 32'h3F800000);
    checkOutput("conj_t1", t1, ConjEn ? 32'hC0000000 : 32'h40000000);
    checkOutput("conj_t3", t3, ConjEn ? 32'h80000000 : 32'h00000000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-frame
    applyStimulus(1'b1, 1'b1, 32'hDEAD0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b1);
    applyReset();
    sendFrame(32'hBEEF0000, 32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003, 1'b0, 1'b1);
    checkOutput("rst_mid_t0", t0, 32'hBEEF0000);
    checkOutput("rst_mid_cnt", {24'b0, err_cnt}, 32'd0);

    // Random traffic: mostly well-framed, occasional framing faults, random backpressure
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 11) == 0) ? 1'($urandom_range(0, 1)) : (partial.size() == 0);
      applyStimulus(v, f, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/quat_stream_rx.md
# quat_stream_rx

Receive side of the serialized quaternion link. It accepts one 32-bit IEEE-754 single-precision component per beat over a valid/ready stream, in the order q0, q1, q2, q3, and reassembles the four beats into a parallel quaternion. The quaternion is presented on a registered valid/ready output, which optionally conjugates it on the way out. It sits between the serial transport and the parallel quaternion math blocks, such as the conjugate and multiply units.

## Interface
- Parameters: none. The component width is fixed at 32 bits, and bit 31 is the sign.
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- s_valid  in  1  An input beat is present.
- s_ready  out  1  The block can accept a beat this cycle.
- s_data  in  32  Component word.
- s_first  in  1  High on the q0 beat only; low on q1–q3.
- s_conj  in  1  Present only with QUAT_RX_CONJ_EN. Sampled on the q3 beat.
- m_valid  out  1  t0..t3 hold a complete quaternion.
- m_ready  in  1  The downstream block accepts the quaternion.
- t0, t1, t2, t3  out  32 each  Reassembled components.
- frame_err  out  1  One-cycle pulse on a framing violation.
- err_cnt  out  8  Saturating count of framing violations.

## Operation
- **Beat transfer.** A beat transfers when s_valid && s_ready. Output transfers when m_valid && m_ready.
- **Beat counter.** The block keeps a staging counter cnt (0..3) and staging registers q0..q2.
  - cnt=0: waiting for q0.
  - cnt=1..3: waiting for q1..q3.
- **Normal beat with s_first matching position** (s_first=1 when cnt=0, s_first=0 when cnt≠0):
  - store the word;
  - increment cnt.
- **q3 accepted (cnt=3):**
  - load t0..t3 from staging plus s_data;
  - set m_valid=1;
  - set cnt=0.
- **s_first=1 while cnt≠0:**
  - discard the partial frame;
  - store s_data as q0;
  - set cnt=1;
  - pulse frame_err;
  - increment err_cnt.
- **s_first=0 while cnt=0:**
  - drop the word;
  - cnt stays 0;
  - pulse frame_err;
  - increment err_cnt.
- **err_cnt** saturates at 255 and never wraps. It is cleared only by rst.
- **Backpressure.** s_ready = (cnt≠3) || !m_valid || m_ready.
  - Beats q0..q2 are always accepted.
  - The q3 beat stalls only while an undrained quaternion sits on the output.
- **Output register.**
  - If a transfer happens and no new q3 arrives in the same cycle, m_valid clears.
  - If a new q3 arrives in the same cycle as a transfer, t0..t3 reload and m_valid stays 1.
  - t0..t3 hold stable while m_valid && !m_ready.
- **Arithmetic.** There is no arithmetic beyond an optional sign-bit inversion. NaN, Inf and denormal values pass through bit-exact except for bit 31.

## Timing
- **Reset values** (rst high at a clock edge):
  - cnt=0, m_valid=0;
  - t0..t3=0;
  - frame_err=0, err_cnt=0;
  - staging registers=0.
  - s_ready is 1 the cycle after reset.
- **Reset mid-frame** discards any partial frame and any pending output. No frame_err pulse is generated.
- **Latency.** m_valid rises on the clock edge that accepts q3, so it is visible the cycle after the q3 beat.
- **Throughput.** One beat per cycle. With m_ready held high, the link sustains one quaternion every 4 cycles with no bubbles.
- **frame_err** is registered. It asserts for exactly the one cycle after the offending beat is accepted.
- **Stalled beats.** A beat presented while s_ready=0 is neither consumed nor checked for framing.

## Configuration
- **QUAT_RX_CONJ_EN defined:**
  - the s_conj port exists;
  - if s_conj=1 on the accepted q3 beat, t1, t2 and t3 load with bit 31 inverted;
  - t0 is never altered.
- **QUAT_RX_CONJ_EN undefined:**
  - the s_conj port is absent;
  - t0..t3 are always raw.

## Test plan
- **Basic frame.** After reset, send 3F800000/40000000/40400000/40800000 (s_first on beat 1), with m_ready=1. Expect m_valid for 1 cycle and t0..t3 = 3F800000/40000000/40400000/40800000.
- **Backpressure.** Hold m_ready=0 and send two back-to-back frames. Expect:
  - s_ready drops while the second frame's q3 is presented;
  - the first frame holds stable on the output;
  - raising m_ready for 1 cycle delivers frame 1, then frame 2 is on the output the next cycle.
- **Framing error, resync.** Send q0, q1, then a beat with s_first=1 (3F800000), then 3 more beats. Expect:
  - frame_err pulses once;
  - err_cnt=1;
  - the output frame starts at 3F800000.
- **Stray beat.** From idle, send 300 beats with s_first=0. Expect:
  - no m_valid;
  - err_cnt saturates at FF;
  - the next correctly framed quaternion is still received correctly.
- **Conjugate (QUAT_RX_CONJ_EN).** Send 3F800000/40000000/C0400000/00000000 with s_conj=1 on q3. Expect t = 3F800000/C0000000/40400000/80000000.
- **Reset mid-frame.** Send q0, q1, assert rst for 1 cycle, then send a full frame. Expect:
  - only the new frame is output;
  - frame_err never asserts.
